// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline constants, state encodings and counter widths
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_t;
  localparam logic [31:0] NOP        = 32'h00000013;
  localparam int          CNT_W      = 16;
  localparam int          WAIT_W     = 8;
  localparam logic [7:0]  WAIT_LIMIT = 8'd255;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use register comparison and dmem stall request
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd_addr,
  input  logic       exmem_mem_req,
  input  logic       dmem_ack,
  output logic       load_use,
  output logic       mem_stall_req
);
  // x0 is hardwired zero, so a load into it can never feed a dependent read
  always_comb begin
    load_use = idex_mem_read && (idex_rd_addr != 5'd0) &&
               ((id_rs1_used && id_rs1_addr == idex_rd_addr) ||
                (id_rs2_used && id_rs2_addr == idex_rd_addr));
    mem_stall_req = exmem_mem_req && !dmem_ack;
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with dmem wait FSM and status counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd_addr,
  input  logic             ex_branch_taken,
  input  logic             exmem_mem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);
  state_t              state_q, state_d;
  logic                load_use, mem_stall_req, mem_stall, branch, lu;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;

  hazard_detect u_hazard (
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .idex_mem_read (idex_mem_read),
    .idex_rd_addr  (idex_rd_addr),
    .exmem_mem_req (exmem_mem_req),
    .dmem_ack      (dmem_ack),
    .load_use      (load_use),
    .mem_stall_req (mem_stall_req)
  );

  assign state = state_q;

  // priority mux (mem stall > branch flush > load-use) and next-state logic
  always_comb begin
    mem_stall    = (state_q == RUN) ? mem_stall_req : (state_q == MEM_WAIT) && !dmem_ack;
    branch       = (state_q == RUN) && !mem_stall && ex_branch_taken;
    lu           = (state_q == RUN) && !mem_stall && !branch && load_use;
    pc_en        = !mem_stall && !lu;
    ifid_en      = !mem_stall && !lu;
    ifid_flush   = branch;
    idex_en      = !mem_stall;
    idex_flush   = branch || lu;
    exmem_en     = !mem_stall;
    memwb_en     = 1'b1;
    memwb_bubble = mem_stall;
    state_d      = ((state_q == RUN && mem_stall_req) || (state_q == MEM_WAIT && !dmem_ack)) ? MEM_WAIT : RUN;
    wait_nxt     = (state_q == RUN && state_d == MEM_WAIT) ? '0 :
                   (state_q == MEM_WAIT && !dmem_ack && wait_cnt != WAIT_LIMIT) ? wait_cnt + WAIT_W'(1) :
                   wait_cnt;
  end

  // state, wait counter, sticky timeout and saturating status counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt    <= wait_nxt;
      mem_timeout <= mem_timeout || (wait_nxt == WAIT_LIMIT);
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, idex_rd_addr;
  logic        id_rs1_used, id_rs2_used, idex_mem_read, ex_branch_taken, exmem_mem_req, dmem_ack;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_timeout;
  int          tests = 0;
  int          fails = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .idex_mem_read(idex_mem_read), .idex_rd_addr(idex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .exmem_mem_req(exmem_mem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .memwb_bubble(memwb_bubble),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs1_addr = 0; id_rs2_addr = 0; idex_rd_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; idex_mem_read = 0;
    ex_branch_taken = 0; exmem_mem_req = 0; dmem_ack = 0;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_idex_flush", idex_flush, 0);
    @(negedge clk); rst = 1'b1;

    @(negedge clk);
    idex_mem_read = 1; idex_rd_addr = 5; id_rs1_addr = 5; id_rs1_used = 1;
    #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_ifid_en", ifid_en, 0);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_idex_en", idex_en, 1);
    chk("lu_exmem_en", exmem_en, 1);
    chk("lu_bubble", memwb_bubble, 0);
    @(negedge clk); clr();
    #1;
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_pc_en_after", pc_en, 1);

    idex_mem_read = 1; idex_rd_addr = 0; id_rs1_addr = 0; id_rs1_used = 1;
    #1;
    chk("x0_pc_en", pc_en, 1);
    chk("x0_idex_flush", idex_flush, 0);
    @(negedge clk); clr();
    idex_mem_read = 1; idex_rd_addr = 7; id_rs2_addr = 7; id_rs2_used = 0;
    #1;
    chk("unused_pc_en", pc_en, 1);
    chk("unused_ifid_en", ifid_en, 1);
    chk("unused_idex_flush", idex_flush, 0);
    @(negedge clk);
    id_rs2_used = 1;
    #1;
    chk("rs2_pc_en", pc_en, 0);
    chk("rs2_idex_flush", idex_flush, 1);
    @(negedge clk); clr();
    #1;
    chk("rs2_stall_cnt", stall_cnt, 2);

    idex_mem_read = 1; idex_rd_addr = 5; id_rs1_addr = 5; id_rs1_used = 1; ex_branch_taken = 1;
    #1;
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_flush", idex_flush, 1);
    chk("br_pc_en", pc_en, 1);
    chk("br_ifid_en", ifid_en, 1);
    @(negedge clk); clr();
    #1;
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 2);

    rst = 1'b0;
    #1;
    chk("rst2_stall_cnt", stall_cnt, 0);
    @(negedge clk); rst = 1'b1;

    @(negedge clk);
    exmem_mem_req = 1; dmem_ack = 0; ex_branch_taken = 1;
    #1;
    chk("mw1_state", state, 0);
    chk("mw1_pc_en", pc_en, 0);
    chk("mw1_exmem_en", exmem_en, 0);
    chk("mw1_memwb_en", memwb_en, 1);
    chk("mw1_bubble", memwb_bubble, 1);
    chk("mw1_ifid_flush", ifid_flush, 0);
    @(negedge clk); #1;
    chk("mw2_state", state, 1);
    chk("mw2_pc_en", pc_en, 0);
    chk("mw2_bubble", memwb_bubble, 1);
    chk("mw2_ifid_flush", ifid_flush, 0);
    @(negedge clk); #1;
    chk("mw3_state", state, 1);
    chk("mw3_idex_en", idex_en, 0);
    @(negedge clk);
    dmem_ack = 1;
    #1;
    chk("ack_state", state, 1);
    chk("ack_pc_en", pc_en, 1);
    chk("ack_bubble", memwb_bubble, 0);
    chk("ack_ifid_flush", ifid_flush, 0);
    @(negedge clk);
    exmem_mem_req = 0; dmem_ack = 0;
    #1;
    chk("post_state", state, 0);
    chk("post_stall_cnt", stall_cnt, 3);
    chk("post_br_flush", ifid_flush, 1);
    @(negedge clk); clr();
    #1;
    chk("post_flush_cnt", flush_cnt, 1);

    exmem_mem_req = 1; dmem_ack = 0;
    repeat (255) @(negedge clk);
    #1;
    chk("to255_timeout", mem_timeout, 0);
    chk("to255_state", state, 1);
    @(negedge clk); #1;
    chk("to256_timeout", mem_timeout, 1);
    repeat (4) @(negedge clk);
    #1;
    chk("to260_timeout", mem_timeout, 1);
    chk("to260_state", state, 1);
    chk("to260_stall_cnt", stall_cnt, 263);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
    chk("arst_timeout", mem_timeout, 0);
    chk("arst_pc_en", pc_en, 0);
    chk("arst_bubble", memwb_bubble, 1);
    clr();
    #1;
    chk("arst_pc_en_clr", pc_en, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("rel_state", state, 0);
    chk("rel_stall_cnt", stall_cnt, 0);
    chk("rel_timeout", mem_timeout, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
